ddr_line_bridge: RTL and testbench
==================================

// Module: ddr_line_bridge
// PURPOSE
// Downstream neighbour of the data cache: turns the cache's 128-bit line read/write requests into
// MIG-style app-interface commands to DDR, and returns line data / completion pulses to the cache.
// One transaction outstanding at a time; writes are posted (fin once DDR has accepted cmd+data).
// PARAMETERS
// ADDR_W       27   byte address width, cache and DDR side
// DATA_W       128  line width (4 words)
// OFFSET_W     4    low address bits cleared to line-align every DDR address
// PORTS
// clk                 in   1       single clock
// rst                 in   1       synchronous reset, active-high
// cache2DDR_rd_addr   in   ADDR_W  line read address
// cache2DDR_rd_en     in   1       read request (rising edge = one request)
// DDR2cache_rd_fin    out  1       1-cycle pulse: DDR2cache_rd_data valid
// DDR2cache_rd_data   out  DATA_W  returned line; held until next rd_fin
// cache2DDR_wr_addr   in   ADDR_W  line write address
// cache2DDR_wr_data   in   DATA_W  full line to write
// cache2DDR_wr_en     in   1       write request (rising edge = one request)
// DDR2cache_wr_fin    out  1       1-cycle pulse: write accepted by DDR
// app_addr            out  ADDR_W  DDR command address, low OFFSET_W bits = 0
// app_cmd             out  3       3'b001 read, 3'b000 write
// app_en              out  1       command valid; held until app_rdy
// app_rdy             in   1       command accepted when app_en&&app_rdy
// app_wdf_data        out  DATA_W  write data
// app_wdf_wren        out  1       write data valid; held until app_wdf_rdy
// app_wdf_end         out  1       equals app_wdf_wren (single-beat line)
// app_wdf_mask        out  DATA_W/8 constant 0
// app_wdf_rdy         in   1       write data accepted when wren&&wdf_rdy
// app_rd_data         in   DATA_W  read data
// app_rd_data_valid   in   1       read data valid (single beat)
// BEHAVIOUR
// - Reset (rst=1 at edge): all outputs 0, state IDLE, pending flags and edge-detect regs cleared.
// - Request capture: rd_en&&!rd_en_q sets rd_pend and latches addr; same for wr (addr+data).
//   Captured in any state; a second edge while that pend is set is dropped (cache never does this).
// - IDLE: if wr_pend -> WR (write priority, keeps read-after-write ordering); else if rd_pend -> RD_CMD.
//   Capture and dispatch may occur in the same cycle as the edge (combinational pend OR edge).
// - RD_CMD: app_en=1, app_cmd=001, app_addr={addr[ADDR_W-1:OFFSET_W],0}. On app_rdy: app_en=0,
//   clear rd_pend, -> RD_WAIT.
// - RD_WAIT: on app_rd_data_valid: DDR2cache_rd_data<=app_rd_data, rd_fin=1 next cycle, -> IDLE.
// - WR: app_en/app_cmd=000 and app_wdf_wren/end asserted together; each dropped independently on its
//   own ready (cmd_done, data_done flags). Both done (incl. same cycle) -> wr_fin=1 next cycle,
//   clear wr_pend, -> IDLE.
// - Latency (ready always high): read = 1 cycle to cmd + DDR read latency + 1 to rd_fin;
//   write = wr_fin 2 cycles after wr_en rising edge.
// - app_rd_data_valid outside RD_WAIT is ignored (no fin, data reg unchanged).
// - rd_fin and wr_fin never both high in one cycle; each is exactly one cycle wide.
// - Reset mid-transaction: transaction abandoned, no fin issued; late app_rd_data_valid ignored.
// - Level-held en (cache may hold rd_en high): only the rising edge counts; no repeat requests.
// TESTING
// - Read, app_rdy=1, DDR returns 128'h0123..CDEF 5 cycles after cmd at addr 27'h00_1234 ->
//   app_addr=27'h00_1230, cmd 001, one rd_fin pulse with that data, data held afterwards.
// - Write addr 27'h00_004C data D, both readies high -> app_addr 27'h00_0040, wdf_data D, mask 0,
//   wr_fin exactly 2 cycles after wr_en edge.
// - app_rdy low 3 cycles, app_wdf_rdy low 6 -> app_en held 4 cycles, wren held 7, one wr_fin
//   after data accepted; reverse ready order gives same single wr_fin.
// - rd_en and wr_en rise same cycle -> write issued and fin'd first, then read cmd; one fin each.
// - rd_en held high 20 cycles -> exactly one DDR read; stray app_rd_data_valid in IDLE -> no rd_fin.
// - rst asserted during RD_WAIT, then valid arrives -> no rd_fin, outputs 0, next read works normally.

Source files
------------

// File: rtl/ddr_line_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_line_bridge_if
// Description : Bundles the two sides of the line bridge. One side carries the
//               cache line request/response signals; the other carries the
//               MIG-style app interface.
//               slave  - view used by the bridge (drives fins, read data and
//                        app commands; receives requests and DDR responses)
//               master - view used by the environment (cache + DDR model)
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_line_bridge_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  localparam int MASK_W = DATA_W / 8;

  // cache side
  logic [ADDR_W-1:0] cache2DDR_rd_addr;
  logic              cache2DDR_rd_en;
  logic              DDR2cache_rd_fin;
  logic [DATA_W-1:0] DDR2cache_rd_data;
  logic [ADDR_W-1:0] cache2DDR_wr_addr;
  logic [DATA_W-1:0] cache2DDR_wr_data;
  logic              cache2DDR_wr_en;
  logic              DDR2cache_wr_fin;

  // DDR app side
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport slave (
    input  cache2DDR_rd_addr, cache2DDR_rd_en,
    input  cache2DDR_wr_addr, cache2DDR_wr_data, cache2DDR_wr_en,
    output DDR2cache_rd_fin, DDR2cache_rd_data, DDR2cache_wr_fin,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
    output app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport master (
    output cache2DDR_rd_addr, cache2DDR_rd_en,
    output cache2DDR_wr_addr, cache2DDR_wr_data, cache2DDR_wr_en,
    input  DDR2cache_rd_fin, DDR2cache_rd_data, DDR2cache_wr_fin,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
    input  app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/ddr_line_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ddr_line_bridge
// Description : Converts 128-bit cache line read/write requests into MIG-style
//               app-interface commands. One transaction outstanding at a time;
//               writes are posted (wr_fin once DDR accepted cmd and data).
// Ports       : clk  - single clock
//               rst  - synchronous reset, active-high
//               bus  - ddr_line_bridge_if.slave (cache requests/fins, app
//                      command/write-data/read-data channels)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_line_bridge #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ddr_line_bridge_if.slave bus
);

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_CMD  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR      = 2'd3
  } state_t;

  state_t state, state_next;

  logic              rd_en_q, wr_en_q;
  logic              rd_pend, wr_pend;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              cmd_done, data_done;
  logic              rd_fin_q, wr_fin_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              rd_edge, wr_edge;
  logic              cmd_acc, data_acc, wr_all_done, rd_acc, rd_ret;
  logic              app_en_c, wren_c;
  logic [2:0]        app_cmd_c;
  logic [ADDR_W-1:0] app_addr_c;
  logic [DATA_W-1:0] wdf_data_c;

  assign rd_edge = bus.cache2DDR_rd_en && !rd_en_q;
  assign wr_edge = bus.cache2DDR_wr_en && !wr_en_q;

  // Handshake qualifiers derived from the current-cycle drive values.
  assign rd_acc      = (state == S_RD_CMD) && bus.app_rdy;
  assign rd_ret      = (state == S_RD_WAIT) && bus.app_rd_data_valid;
  assign cmd_acc     = app_en_c && bus.app_rdy;
  assign data_acc    = wren_c && bus.app_wdf_rdy;
  // Command and data may complete in either order or together.
  assign wr_all_done = (state == S_WR) && (cmd_done || cmd_acc) && (data_done || data_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    app_en_c   = 1'b0;
    app_cmd_c  = CMD_WRITE;
    app_addr_c = '0;
    wren_c     = 1'b0;
    wdf_data_c = '0;
    case (state)
      S_IDLE: begin
        // A request edge this cycle dispatches immediately; writes go first
        // so a read issued after a write to the same line sees new data.
        if (wr_pend || wr_edge) begin
          state_next = S_WR;
        end else if (rd_pend || rd_edge) begin
          state_next = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        app_en_c   = 1'b1;
        app_cmd_c  = CMD_READ;
        app_addr_c = {rd_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (bus.app_rdy) begin
          state_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.app_rd_data_valid) begin
          state_next = S_IDLE;
        end
      end
      S_WR: begin
        app_en_c   = !cmd_done;
        app_cmd_c  = CMD_WRITE;
        app_addr_c = {wr_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        wren_c     = !data_done;
        wdf_data_c = wr_data_q;
        if (wr_all_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
      rd_fin_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_en_q  <= bus.cache2DDR_rd_en;
      wr_en_q  <= bus.cache2DDR_wr_en;
      rd_fin_q <= rd_ret;
      wr_fin_q <= wr_all_done;

      // A pending request is never both cleared and re-captured in one cycle:
      // an edge arriving while pend is set is dropped.
      if (rd_acc) begin
        rd_pend <= 1'b0;
      end
      if (rd_edge && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= bus.cache2DDR_rd_addr;
      end

      if (wr_all_done) begin
        wr_pend <= 1'b0;
      end
      if (wr_edge && !wr_pend) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= bus.cache2DDR_wr_addr;
        wr_data_q <= bus.cache2DDR_wr_data;
      end

      if (wr_all_done || (state != S_WR)) begin
        cmd_done  <= 1'b0;
        data_done <= 1'b0;
      end else begin
        if (cmd_acc) begin
          cmd_done <= 1'b1;
        end
        if (data_acc) begin
          data_done <= 1'b1;
        end
      end

      if (rd_ret) begin
        rd_data_q <= bus.app_rd_data;
      end
    end
  end

  assign bus.app_en            = app_en_c;
  assign bus.app_cmd           = app_cmd_c;
  assign bus.app_addr          = app_addr_c;
  assign bus.app_wdf_wren      = wren_c;
  assign bus.app_wdf_end       = wren_c;
  assign bus.app_wdf_data      = wdf_data_c;
  assign bus.app_wdf_mask      = '0;
  assign bus.DDR2cache_rd_fin  = rd_fin_q;
  assign bus.DDR2cache_wr_fin  = wr_fin_q;
  assign bus.DDR2cache_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_line_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_line_bridge
// Description : Directed self-checking bench for ddr_line_bridge. Inputs are
//               driven just after the falling edge; outputs are sampled at the
//               falling edge. A posedge monitor counts fin pulses and read
//               commands issued to DDR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_line_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_line_bridge_if #(.ADDR_W(27), .DATA_W(128)) bus ();

  ddr_line_bridge #(.ADDR_W(27), .DATA_W(128), .OFFSET_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rd_fin_cnt = 0;
  int wr_fin_cnt = 0;
  int rd_cmd_cnt = 0;
  int both_cnt   = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D3 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D5 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] D6 = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] D7 = 128'h0000000F_000000F0_00000F00_0000F000;

  always @(posedge clk) begin
    if (bus.DDR2cache_rd_fin) rd_fin_cnt++;
    if (bus.DDR2cache_wr_fin) wr_fin_cnt++;
    if (bus.DDR2cache_rd_fin && bus.DDR2cache_wr_fin) both_cnt++;
    if (bus.app_en && bus.app_rdy && (bus.app_cmd == 3'b001)) rd_cmd_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write with ready stalls: app_rdy rises after a_low cycles, app_wdf_rdy
  // after d_low cycles. Expected counts are supplied by the caller.
  task automatic run_stall(input int a_low, input int d_low, input int exp_en,
                           input int exp_wren, input int exp_fin_at);
    int en_cnt, wren_cnt, fin_cnt, fin_at;
    en_cnt = 0; wren_cnt = 0; fin_cnt = 0; fin_at = 0;
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    bus.cache2DDR_wr_addr = 27'h00_0100;
    bus.cache2DDR_wr_data = D2;
    bus.cache2DDR_wr_en = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      if (bus.app_en) en_cnt++;
      if (bus.app_wdf_wren) wren_cnt++;
      if (bus.DDR2cache_wr_fin) begin
        fin_cnt++;
        fin_at = i;
      end
      bus.cache2DDR_wr_en = 1'b0;
      bus.app_rdy = (i >= a_low + 1);
      bus.app_wdf_rdy = (i >= d_low + 1);
    end
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    check("stall_app_en_cycles", 128'(en_cnt), 128'(exp_en));
    check("stall_wren_cycles", 128'(wren_cnt), 128'(exp_wren));
    check("stall_wr_fin_count", 128'(fin_cnt), 128'd1);
    check("stall_wr_fin_cycle", 128'(fin_at), 128'(exp_fin_at));
  endtask

  int r0, w0, c0;

  initial begin
    bus.cache2DDR_rd_addr = '0;
    bus.cache2DDR_rd_en   = 1'b0;
    bus.cache2DDR_wr_addr = '0;
    bus.cache2DDR_wr_data = '0;
    bus.cache2DDR_wr_en   = 1'b0;
    bus.app_rdy           = 1'b0;
    bus.app_wdf_rdy       = 1'b0;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;

    // Reset state
    cyc(3);
    check("reset_ctrl", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end,
                         bus.DDR2cache_rd_fin, bus.DDR2cache_wr_fin}, 5'b0);
    check("reset_addr", bus.app_addr, '0);
    check("reset_rd_data", bus.DDR2cache_rd_data, '0);
    rst = 1'b0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    cyc(2);

    // Basic read, DDR returns 5 cycles after command acceptance
    bus.cache2DDR_rd_addr = 27'h00_1234;
    bus.cache2DDR_rd_en = 1'b1;
    cyc(1);
    check("rd_cmd_en", bus.app_en, 1'b1);
    check("rd_cmd_code", bus.app_cmd, 3'b001);
    check("rd_cmd_addr", bus.app_addr, 27'h00_1230);
    bus.cache2DDR_rd_en = 1'b0;
    cyc(1);
    check("rd_cmd_dropped", bus.app_en, 1'b0);
    cyc(4);
    check("rd_no_early_fin", bus.DDR2cache_rd_fin, 1'b0);
    bus.app_rd_data = D1;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    check("rd_fin_pulse", bus.DDR2cache_rd_fin, 1'b1);
    check("rd_fin_data", bus.DDR2cache_rd_data, D1);
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;
    cyc(1);
    check("rd_fin_one_cycle", bus.DDR2cache_rd_fin, 1'b0);
    check("rd_data_held", bus.DDR2cache_rd_data, D1);

    // Basic write, both readies high
    bus.cache2DDR_wr_addr = 27'h00_004C;
    bus.cache2DDR_wr_data = D2;
    bus.cache2DDR_wr_en = 1'b1;
    cyc(1);
    check("wr_cmd_en", bus.app_en, 1'b1);
    check("wr_cmd_code", bus.app_cmd, 3'b000);
    check("wr_cmd_addr", bus.app_addr, 27'h00_0040);
    check("wr_wdf_data", bus.app_wdf_data, D2);
    check("wr_wren_end", {bus.app_wdf_wren, bus.app_wdf_end}, 2'b11);
    check("wr_mask", bus.app_wdf_mask, 16'h0);
    check("wr_no_early_fin", bus.DDR2cache_wr_fin, 1'b0);
    bus.cache2DDR_wr_en = 1'b0;
    cyc(1);
    check("wr_fin_pulse", bus.DDR2cache_wr_fin, 1'b1);
    check("wr_en_dropped", {bus.app_en, bus.app_wdf_wren}, 2'b00);
    cyc(1);
    check("wr_fin_one_cycle", bus.DDR2cache_wr_fin, 1'b0);

    // Ready stalls in both orders
    run_stall(3, 6, 4, 7, 8);
    run_stall(6, 3, 7, 4, 8);

    // Simultaneous read and write edges: write first
    r0 = rd_fin_cnt; w0 = wr_fin_cnt;
    bus.cache2DDR_rd_addr = 27'h00_ABC5;
    bus.cache2DDR_wr_addr = 27'h7FF_FFFF;
    bus.cache2DDR_wr_data = D3;
    bus.cache2DDR_rd_en = 1'b1;
    bus.cache2DDR_wr_en = 1'b1;
    cyc(1);
    check("both_first_is_wr", {bus.app_en, bus.app_cmd}, 4'b1000);
    check("both_wr_addr", bus.app_addr, 27'h7FF_FFF0);
    bus.cache2DDR_rd_en = 1'b0;
    bus.cache2DDR_wr_en = 1'b0;
    cyc(1);
    check("both_wr_fin", bus.DDR2cache_wr_fin, 1'b1);
    cyc(1);
    check("both_then_rd", {bus.app_en, bus.app_cmd}, 4'b1001);
    check("both_rd_addr", bus.app_addr, 27'h00_ABC0);
    cyc(1);
    bus.app_rd_data = D3;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    check("both_rd_fin_data", {bus.DDR2cache_rd_fin, bus.DDR2cache_rd_data}, {1'b1, D3});
    bus.app_rd_data_valid = 1'b0;
    cyc(3);
    check("both_rd_fin_count", 128'(rd_fin_cnt - r0), 128'd1);
    check("both_wr_fin_count", 128'(wr_fin_cnt - w0), 128'd1);

    // Level-held rd_en: only one DDR read
    r0 = rd_fin_cnt; c0 = rd_cmd_cnt;
    bus.cache2DDR_rd_addr = 27'h00_2000;
    bus.cache2DDR_rd_en = 1'b1;
    cyc(3);
    bus.app_rd_data = D4;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    bus.app_rd_data_valid = 1'b0;
    cyc(16);
    bus.cache2DDR_rd_en = 1'b0;
    cyc(2);
    check("held_rd_cmd_count", 128'(rd_cmd_cnt - c0), 128'd1);
    check("held_rd_fin_count", 128'(rd_fin_cnt - r0), 128'd1);

    // Stray read-data valid while idle
    r0 = rd_fin_cnt;
    bus.app_rd_data = D5;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    bus.app_rd_data_valid = 1'b0;
    cyc(2);
    check("stray_no_fin", 128'(rd_fin_cnt - r0), 128'd0);
    check("stray_data_kept", bus.DDR2cache_rd_data, D4);

    // Reset during RD_WAIT
    bus.cache2DDR_rd_addr = 27'h00_3330;
    bus.cache2DDR_rd_en = 1'b1;
    cyc(1);
    bus.cache2DDR_rd_en = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_outputs", {bus.app_en, bus.app_wdf_wren, bus.DDR2cache_rd_fin,
                             bus.DDR2cache_wr_fin}, 4'b0);
    check("midrst_rd_data", bus.DDR2cache_rd_data, '0);
    r0 = rd_fin_cnt;
    bus.app_rd_data = D6;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    bus.app_rd_data_valid = 1'b0;
    cyc(2);
    check("midrst_late_valid_no_fin", 128'(rd_fin_cnt - r0), 128'd0);
    check("midrst_late_valid_data", bus.DDR2cache_rd_data, '0);

    // Normal read after reset
    bus.cache2DDR_rd_addr = 27'h00_5555;
    bus.cache2DDR_rd_en = 1'b1;
    cyc(1);
    check("post_rst_rd_cmd", {bus.app_en, bus.app_cmd}, 4'b1001);
    check("post_rst_rd_addr", bus.app_addr, 27'h00_5550);
    bus.cache2DDR_rd_en = 1'b0;
    cyc(1);
    bus.app_rd_data = D7;
    bus.app_rd_data_valid = 1'b1;
    cyc(1);
    check("post_rst_rd_fin", {bus.DDR2cache_rd_fin, bus.DDR2cache_rd_data}, {1'b1, D7});
    bus.app_rd_data_valid = 1'b0;
    cyc(2);
    check("never_both_fins", 128'(both_cnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
